// File: rtl/dcache_dm_wt_if.sv
// Core-side and memory-side signals of the direct-mapped write-through data cache.
// The cache uses the slave modport; the core/memory environment uses master.
// Hit/miss counters travel with the bus so observers see them next to the traffic.
interface dcache_dm_wt_if;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_rdata;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, mem_rdata,
      output cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_rd, mem_wr,
             hit_cnt, miss_cnt
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, mem_rdata,
      input  cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_rd, mem_wr,
             hit_cnt, miss_cnt
   );
endinterface

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate one-word-line data cache.
// Latency: load hit 1 cycle; load miss and store MEM_LATENCY+1 cycles.
// Backpressure: cpu_stall holds the core during misses/stores; drops in the final cycle.
module dcache_dm_wt #(
   parameter int INDEX_BITS  = 4,
   parameter int MEM_LATENCY = 2
) (
   input  logic           clk,
   input  logic           rst,
   dcache_dm_wt_if.slave  bus
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 30 - INDEX_BITS;
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, RFILL, WRITE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [29:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [31:0]        data_q [LINES];
   logic [31:0]        hit_cnt_q, miss_cnt_q;

   logic [INDEX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0]      req_tag, fill_tag;
   logic                  lookup_hit, last;
   logic                  hit_inc, miss_inc, fill_we, store_we;

   logic [31:0] cpu_rdata_o, mem_addr_o, mem_wdata_o;
   logic        cpu_stall_o, mem_rd_o, mem_wr_o;

   // Tag lookup on the live request; fill/store side works from the latched word address.
   always_comb begin
      req_idx    = bus.cpu_addr[INDEX_BITS+1:2];
      req_tag    = bus.cpu_addr[31:INDEX_BITS+2];
      lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
      fill_idx   = addr_q[INDEX_BITS-1:0];
      fill_tag   = addr_q[29:INDEX_BITS];
      last       = (cnt_q == CNT_W'(MEM_LATENCY - 1));
   end

   // Next state and outputs; reset forces every output low and suppresses array writes.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      hit_inc     = 1'b0;
      miss_inc    = 1'b0;
      fill_we     = 1'b0;
      store_we    = 1'b0;
      cpu_rdata_o = '0;
      cpu_stall_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_rd_o    = 1'b0;
      mem_wr_o    = 1'b0;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               if (bus.cpu_wr) begin
                  cpu_stall_o = 1'b1;
                  addr_d      = bus.cpu_addr[31:2];
                  wdata_d     = bus.cpu_wdata;
                  store_we    = lookup_hit;
                  cnt_d       = '0;
                  state_d     = WRITE;
               end else if (bus.cpu_rd) begin
                  if (lookup_hit) begin
                     cpu_rdata_o = data_q[req_idx];
                     hit_inc     = 1'b1;
                  end else begin
                     cpu_stall_o = 1'b1;
                     addr_d      = bus.cpu_addr[31:2];
                     miss_inc    = 1'b1;
                     cnt_d       = '0;
                     state_d     = RFILL;
                  end
               end
            end
            RFILL: begin
               mem_rd_o    = 1'b1;
               mem_addr_o  = {addr_q, 2'b00};
               cpu_stall_o = !last;
               if (last) begin
                  cpu_rdata_o = bus.mem_rdata;
                  fill_we     = 1'b1;
                  cnt_d       = '0;
                  state_d     = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WRITE: begin
               // Memory takes the write on the single cnt==0 strobe; the rest is latency padding.
               mem_wr_o    = (cnt_q == '0);
               mem_addr_o  = {addr_q, 2'b00};
               mem_wdata_o = wdata_q;
               cpu_stall_o = !last;
               if (last) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control state, latched request and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hit_cnt_q  <= hit_cnt_q + {31'd0, hit_inc};
         miss_cnt_q <= miss_cnt_q + {31'd0, miss_inc};
      end
   end

   // Valid bits: cleared by reset, set when a fill completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (fill_we) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag/data arrays need no reset; valid_q guards them.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= bus.mem_rdata;
      end else if (store_we) begin
         data_q[req_idx] <= bus.cpu_wdata;
      end
   end

   assign bus.cpu_rdata = cpu_rdata_o;
   assign bus.cpu_stall = cpu_stall_o;
   assign bus.mem_addr  = mem_addr_o;
   assign bus.mem_wdata = mem_wdata_o;
   assign bus.mem_rd    = mem_rd_o;
   assign bus.mem_wr    = mem_wr_o;
   assign bus.hit_cnt   = hit_cnt_q;
   assign bus.miss_cnt  = miss_cnt_q;
endmodule
